// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - LC-3b MEM-stage sequencer for one or two chained data-memory accesses.
// Optional misaligned-word flag enabled by defining MAU_ALIGN_CHECK_EN.
module mem_access_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [3:0]  opcode,
   input  logic [1:0]  acc_count,
   input  logic [15:0] addr,
   input  logic [15:0] store_data,
   input  logic        dmem_resp,
   input  logic [15:0] dmem_rdata,
   output logic        dmem_read,
   output logic        dmem_write,
   output logic [15:0] dmem_address,
   output logic [15:0] dmem_wdata,
   output logic [1:0]  dmem_byte_enable,
   output logic        stall,
   output logic        done,
   output logic [15:0] load_data,
   output logic        misalign
);

   localparam logic [3:0] OP_LDB = 4'h2;
   localparam logic [3:0] OP_STB = 4'h3;
   localparam logic [3:0] OP_LDR = 4'h6;
   localparam logic [3:0] OP_STR = 4'h7;
   localparam logic [3:0] OP_LDI = 4'hA;
   localparam logic [3:0] OP_STI = 4'hB;

   typedef enum logic [1:0] {IDLE, ACC1, ACC2, DONE} state_t;

   state_t      state_q, state_d;
   logic [3:0]  op_q, op_d;
   logic [15:0] sd_q, sd_d;
   logic        sel_q, sel_d;
   logic        two_q, two_d;
   logic        rd_q, rd_d;
   logic        wr_q, wr_d;
   logic [15:0] daddr_q, daddr_d;
   logic [15:0] wdata_q, wdata_d;
   logic [1:0]  be_q, be_d;
   logic        done_q, done_d;
   logic [15:0] ldata_q, ldata_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         op_q    <= 4'h0;
         sd_q    <= 16'h0;
         sel_q   <= 1'b0;
         two_q   <= 1'b0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         daddr_q <= 16'h0;
         wdata_q <= 16'h0;
         be_q    <= 2'b00;
         done_q  <= 1'b0;
         ldata_q <= 16'h0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         sd_q    <= sd_d;
         sel_q   <= sel_d;
         two_q   <= two_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         daddr_q <= daddr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         done_q  <= done_d;
         ldata_q <= ldata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      sd_d    = sd_q;
      sel_d   = sel_q;
      two_d   = two_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      daddr_d = daddr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      done_d  = 1'b0;
      ldata_d = ldata_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = ACC1;
               op_d    = opcode;
               sd_d    = store_data;
               sel_d   = addr[0];
               two_d   = (acc_count == 2'b10);
               wr_d    = (opcode == OP_STR) || (opcode == OP_STB);
               rd_d    = !((opcode == OP_STR) || (opcode == OP_STB));
               daddr_d = {addr[15:1], 1'b0};
               if (opcode == OP_STB) begin
                  wdata_d = {store_data[7:0], store_data[7:0]};
                  be_d    = addr[0] ? 2'b10 : 2'b01;
               end else begin
                  wdata_d = store_data;
                  be_d    = 2'b11;
               end
            end
         end
         ACC1: begin
            if (dmem_resp) begin
               rd_d = 1'b0;
               wr_d = 1'b0;
               if (!start) begin
                  state_d = IDLE;
               end else if (two_q) begin
                  // Pointer fetched: chain straight into the second access.
                  state_d = ACC2;
                  rd_d    = (op_q == OP_LDI);
                  wr_d    = (op_q == OP_STI);
                  daddr_d = {dmem_rdata[15:1], 1'b0};
                  wdata_d = sd_q;
                  be_d    = 2'b11;
               end else begin
                  state_d = DONE;
                  done_d  = 1'b1;
                  if (op_q == OP_LDB)
                     ldata_d = {8'h00, sel_q ? dmem_rdata[15:8] : dmem_rdata[7:0]};
                  else
                     ldata_d = dmem_rdata;
               end
            end
         end
         ACC2: begin
            if (dmem_resp) begin
               rd_d = 1'b0;
               wr_d = 1'b0;
               if (start) begin
                  state_d = DONE;
                  done_d  = 1'b1;
                  ldata_d = dmem_rdata;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

`ifdef MAU_ALIGN_CHECK_EN
   logic mis_acc_q, mis_acc_d;
   logic mis_q, mis_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         mis_acc_q <= 1'b0;
         mis_q     <= 1'b0;
      end else begin
         mis_acc_q <= mis_acc_d;
         mis_q     <= mis_d;
      end
   end

   // Accumulate over the effective address and, for LDI/STI, the fetched pointer.
   always_comb begin
      mis_acc_d = mis_acc_q;
      if (state_q == IDLE && start)
         mis_acc_d = addr[0] && ((opcode == OP_LDR) || (opcode == OP_STR) ||
                                 (opcode == OP_LDI) || (opcode == OP_STI));
      else if (state_q == ACC1 && dmem_resp && two_q)
         mis_acc_d = mis_acc_q | dmem_rdata[0];
      mis_d = done_d & mis_acc_q;
   end

   assign misalign = mis_q;
`else
   assign misalign = 1'b0;
`endif

   assign dmem_read        = rd_q;
   assign dmem_write       = wr_q;
   assign dmem_address     = daddr_q;
   assign dmem_wdata       = wdata_q;
   assign dmem_byte_enable = be_q;
   assign done             = done_q;
   assign load_data        = ldata_q;
   assign stall            = start & (state_q != DONE);

endmodule
